// File: rtl/johnson_pkg.sv
// Shared helpers for the Johnson ring: direction encoding plus legality and
// position functions that work on a zero-extended ring of any width up to 32.
package johnson_pkg;

  localparam int JC_MAX_W = 32;
  localparam int JC_POS_W = 6;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // A legal ring has at most one boundary between adjacent bits in the used width.
  function automatic logic jc_is_legal(input logic [JC_MAX_W-1:0] q, input int width);
    int n_edges;
    n_edges = 0;
    for (int i = 0; i < JC_MAX_W - 1; i++) begin
      if ((i < width - 1) && (q[i] != q[i+1])) n_edges++;
    end
    return (n_edges <= 1);
  endfunction

  // Only meaningful for legal rings: low-justified ones give pos=ones,
  // high-justified ones give pos=2*width-ones.
  function automatic logic [JC_POS_W-1:0] jc_pos(input logic [JC_MAX_W-1:0] q, input int width);
    int ones;
    ones = 0;
    for (int i = 0; i < JC_MAX_W; i++) begin
      if (q[i]) ones++;
    end
    if (q == '0) return '0;
    else if (q[0]) return JC_POS_W'(ones);
    else return JC_POS_W'(2 * width - ones);
  endfunction

endpackage

// File: rtl/johnson_counter_ring_decode.sv
// Combinational decode of a Johnson ring into legality, position index and
// one-hot state; illegal rings decode to pos=0 and an all-zero one-hot.
module johnson_decode
  import johnson_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int PW    = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0]   q,
  output logic               legal,
  output logic [PW-1:0]      pos,
  output logic [2*WIDTH-1:0] dec
);

  logic [JC_POS_W-1:0] raw_pos;

  always_comb begin
    legal   = jc_is_legal(JC_MAX_W'(q), WIDTH);
    raw_pos = jc_pos(JC_MAX_W'(q), WIDTH);
    pos     = '0;
    dec     = '0;
    if (legal) begin
      pos = PW'(raw_pos);
      dec = (2 * WIDTH)'(1) << pos;
    end
  end

endmodule

// File: rtl/johnson_counter_ring.sv
// Johnson (twisted-ring) counter with enable, direction, seed load and
// automatic recovery from illegal ring contents.
module johnson_counter_ring
  import johnson_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int PW    = $clog2(2 * WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               dir,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  output logic [WIDTH-1:0]   q,
  output logic [PW-1:0]      pos,
  output logic [2*WIDTH-1:0] dec,
  output logic               wrap,
  output logic               err
);

  if (WIDTH < 2 || WIDTH > JC_MAX_W) begin : g_width_check
    $error("johnson_counter_ring: WIDTH must be in 2..32");
  end

  // Ring value at pos 2*WIDTH-1; an up step from here wraps to zero.
  localparam logic [WIDTH-1:0] RING_LAST = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] ring_q, ring_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             ring_legal;
  logic             load_legal;

  johnson_decode #(.WIDTH(WIDTH)) u_decode (
    .q     (ring_q),
    .legal (ring_legal),
    .pos   (pos),
    .dec   (dec)
  );

  always_comb begin
    load_legal = jc_is_legal(JC_MAX_W'(load_val), WIDTH);
    ring_d     = ring_q;
    wrap_d     = 1'b0;
    err_d      = 1'b0;
    if (load) begin
      if (load_legal) begin
        ring_d = load_val;
      end else begin
        ring_d = '0;
        err_d  = 1'b1;
      end
    end else if (!ring_legal) begin
      ring_d = '0;
      err_d  = 1'b1;
    end else if (en) begin
      if (dir == DIR_DN) begin
        ring_d = {~ring_q[0], ring_q[WIDTH-1:1]};
        wrap_d = (ring_q == '0);
      end else begin
        ring_d = {ring_q[WIDTH-2:0], ~ring_q[WIDTH-1]};
        wrap_d = (ring_q == RING_LAST);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ring_q <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      ring_q <= ring_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign q    = ring_q;
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule

// File: tb/tb_johnson_counter_ring.sv
// Self-checking bench: three ring widths (2, 4, 7) run in lockstep against a
// position-based reference model feeding an expected-value queue.
module tb_johnson_counter_ring;

  logic       clk = 1'b0;
  logic       rst, en, dir, load;
  logic [1:0] lv2;
  logic [3:0] lv4;
  logic [6:0] lv7;

  logic [1:0]  q2;  logic [1:0] pos2; logic [3:0]  dec2;  logic wrap2, err2;
  logic [3:0]  q4;  logic [2:0] pos4; logic [7:0]  dec4;  logic wrap4, err4;
  logic [6:0]  q7;  logic [3:0] pos7; logic [13:0] dec7;  logic wrap7, err7;

  always #5 clk = ~clk;

  johnson_counter_ring #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(lv2),
    .q(q2), .pos(pos2), .dec(dec2), .wrap(wrap2), .err(err2));
  johnson_counter_ring #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(lv4),
    .q(q4), .pos(pos4), .dec(dec4), .wrap(wrap4), .err(err4));
  johnson_counter_ring #(.WIDTH(7)) dut7 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(lv7),
    .q(q7), .pos(pos7), .dec(dec7), .wrap(wrap7), .err(err7));

  logic [31:0] act_q   [3];
  logic [5:0]  act_pos [3];
  logic [63:0] act_dec [3];
  logic        act_wrap[3];
  logic        act_err [3];

  assign act_q[0] = 32'(q2); assign act_pos[0] = 6'(pos2); assign act_dec[0] = 64'(dec2);
  assign act_q[1] = 32'(q4); assign act_pos[1] = 6'(pos4); assign act_dec[1] = 64'(dec4);
  assign act_q[2] = 32'(q7); assign act_pos[2] = 6'(pos7); assign act_dec[2] = 64'(dec7);
  assign act_wrap[0] = wrap2; assign act_wrap[1] = wrap4; assign act_wrap[2] = wrap7;
  assign act_err[0]  = err2;  assign act_err[1]  = err4;  assign act_err[2]  = err7;

  typedef struct {
    int          idx;
    logic [31:0] q;
    int          pos;
    logic [63:0] dec;
    logic        wrap;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   wd[3] = '{2, 4, 7};
  int   mpos[3];
  bit   mill[3];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [31:0] q_of_pos(input int p, input int w);
    logic [63:0] v;
    if (p == 0)      v = 64'd0;
    else if (p <= w) v = (64'd1 << p) - 64'd1;
    else             v = ((64'd1 << (2 * w - p)) - 64'd1) << (p - w);
    return v[31:0];
  endfunction

  function automatic int pos_of_q(input logic [31:0] v, input int w);
    for (int p = 0; p < 2 * w; p++) begin
      if (q_of_pos(p, w) == v) return p;
    end
    return -1;
  endfunction

  function automatic logic [31:0] lv_of(input int i);
    if (i == 0) return 32'(lv2);
    else if (i == 1) return 32'(lv4);
    else return 32'(lv7);
  endfunction

  // Advance the reference model with the inputs about to be sampled and queue
  // what each DUT must show after the edge.
  task automatic model_push();
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      int   w, p;
      w = wd[i];
      e.idx = i; e.wrap = 1'b0; e.err = 1'b0;
      if (rst) begin
        mpos[i] = 0; mill[i] = 1'b0;
      end else if (load) begin
        p = pos_of_q(lv_of(i), w);
        if (p < 0) begin mpos[i] = 0; e.err = 1'b1; end
        else mpos[i] = p;
        mill[i] = 1'b0;
      end else if (mill[i]) begin
        mpos[i] = 0; mill[i] = 1'b0; e.err = 1'b1;
      end else if (en) begin
        if (!dir) begin
          e.wrap  = (mpos[i] == 2 * w - 1);
          mpos[i] = (mpos[i] + 1) % (2 * w);
        end else begin
          e.wrap  = (mpos[i] == 0);
          mpos[i] = (mpos[i] + 2 * w - 1) % (2 * w);
        end
      end
      e.q   = q_of_pos(mpos[i], w);
      e.pos = mpos[i];
      e.dec = 64'd1 << mpos[i];
      sb.push_back(e);
    end
  endtask

  task automatic tick();
    model_push();
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL sb_empty: no expected entry queued");
      end else begin
        e = sb.pop_front();
        n_checks++;
        if (act_q[e.idx] !== e.q || act_pos[e.idx] !== 6'(e.pos) || act_dec[e.idx] !== e.dec ||
            act_wrap[e.idx] !== e.wrap || act_err[e.idx] !== e.err) begin
          n_fail++;
          $display("FAIL sb_w%0d: got q=%h pos=%0d dec=%h wrap=%b err=%b, want q=%h pos=%0d dec=%h wrap=%b err=%b at %0t",
                   wd[e.idx], act_q[e.idx], act_pos[e.idx], act_dec[e.idx], act_wrap[e.idx], act_err[e.idx],
                   e.q, e.pos, e.dec, e.wrap, e.err, $time);
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; load = 1'b0; en = 1'b0; dir = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; dir = 1'b0; load = 1'b0;
    tick();
    rst = 1'b0; en = 1'b0;
    n_checks++;
    if (q4 !== 4'b0000 || pos4 !== 3'd0 || dec4 !== 8'b0000_0001 || wrap4 !== 1'b0 || err4 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got q=%b pos=%0d dec=%b wrap=%b err=%b, want 0000/0/00000001/0/0",
               q4, pos4, dec4, wrap4, err4);
    end
  endtask

  task automatic test_count_up();
    logic [3:0] seq [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    do_reset();
    en = 1'b1; dir = 1'b0;
    for (int c = 0; c < 16; c++) begin
      tick();
      n_checks++;
      if (q4 !== seq[c % 8] || pos4 !== 3'((c + 1) % 8) || wrap4 !== (c % 8 == 7)) begin
        n_fail++;
        $display("FAIL count_up step %0d: got q=%b pos=%0d wrap=%b, want q=%b pos=%0d wrap=%b",
                 c, q4, pos4, wrap4, seq[c % 8], (c + 1) % 8, (c % 8 == 7));
      end
    end
    en = 1'b0;
  endtask

  task automatic test_dir_change();
    int want_pos [4] = '{2, 1, 0, 7};
    do_reset();
    en = 1'b1; dir = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (q4 !== 4'b0111) begin
      n_fail++;
      $display("FAIL dir_setup: got q=%b, want 0111", q4);
    end
    dir = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if (pos4 !== 3'(want_pos[c]) || wrap4 !== (c == 3)) begin
        n_fail++;
        $display("FAIL dir_down step %0d: got pos=%0d wrap=%b, want pos=%0d wrap=%b",
                 c, pos4, wrap4, want_pos[c], (c == 3));
      end
    end
    en = 1'b0; dir = 1'b0;
  endtask

  task automatic test_load_legal();
    do_reset();
    en = 1'b1; dir = 1'b0; load = 1'b1;
    lv2 = 2'b10; lv4 = 4'b1100; lv7 = 7'b1111000;
    tick();
    load = 1'b0;
    n_checks++;
    if (q4 !== 4'b1100 || pos4 !== 3'd6 || dec4 !== 8'b0100_0000 || err4 !== 1'b0) begin
      n_fail++;
      $display("FAIL load_legal: got q=%b pos=%0d dec=%b err=%b, want 1100/6/01000000/0",
               q4, pos4, dec4, err4);
    end
    tick();
    n_checks++;
    if (q4 !== 4'b1000) begin
      n_fail++;
      $display("FAIL load_resume: got q=%b, want 1000", q4);
    end
    en = 1'b0;
  endtask

  task automatic test_load_illegal();
    do_reset();
    en = 1'b1; dir = 1'b0; load = 1'b1;
    lv2 = 2'b11; lv4 = 4'b0101; lv7 = 7'b0100000;
    tick();
    load = 1'b0;
    n_checks++;
    if (q4 !== 4'b0000 || err4 !== 1'b1 || pos4 !== 3'd0 || err7 !== 1'b1 || err2 !== 1'b0) begin
      n_fail++;
      $display("FAIL load_illegal: got q=%b err=%b pos=%0d err7=%b err2=%b, want 0000/1/0/1/0",
               q4, err4, pos4, err7, err2);
    end
    tick();
    n_checks++;
    if (q4 !== 4'b0001 || err4 !== 1'b0) begin
      n_fail++;
      $display("FAIL load_illegal_resume: got q=%b err=%b, want 0001/0", q4, err4);
    end
    en = 1'b0;
  endtask

  task automatic test_illegal_fix();
    do_reset();
    en = 1'b0; load = 1'b0;
    dut4.ring_q = 4'b1010;
    mill[1] = 1'b1;
    #1;
    n_checks++;
    if (pos4 !== 3'd0 || dec4 !== 8'd0) begin
      n_fail++;
      $display("FAIL illegal_decode: got pos=%0d dec=%b, want 0/00000000", pos4, dec4);
    end
    tick();
    n_checks++;
    if (q4 !== 4'b0000 || err4 !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_fix: got q=%b err=%b, want 0000/1", q4, err4);
    end
    tick();
    n_checks++;
    if (err4 !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_err_pulse: got err=%b, want 0", err4);
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    en = 1'b1; dir = 1'b0;
    repeat (5) tick();
    n_checks++;
    if (q4 !== 4'b1110) begin
      n_fail++;
      $display("FAIL rst_mid_setup: got q=%b, want 1110", q4);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (q4 !== 4'b0000 || wrap4 !== 1'b0 || err4 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: got q=%b wrap=%b err=%b, want 0000/0/0", q4, wrap4, err4);
    end
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (wrap4 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_clears_wrap: got wrap=%b, want 0", wrap4);
    end
    en = 1'b0;
  endtask

  task automatic test_period();
    int wraps [3];
    int want  [3] = '{7, 3, 2};
    do_reset();
    en = 1'b1; dir = 1'b0;
    wraps = '{0, 0, 0};
    for (int c = 0; c < 28; c++) begin
      tick();
      for (int i = 0; i < 3; i++) if (act_wrap[i]) wraps[i]++;
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (wraps[i] != want[i]) begin
        n_fail++;
        $display("FAIL period_w%0d: got %0d wraps in 28 cycles, want %0d", wd[i], wraps[i], want[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 300; c++) begin
      rst  = ($urandom_range(0, 39) == 0);
      load = ($urandom_range(0, 7) == 0);
      en   = ($urandom_range(0, 3) != 0);
      dir  = $urandom_range(0, 1) == 1;
      lv2  = 2'($urandom);
      lv4  = 4'($urandom);
      lv7  = 7'($urandom);
      tick();
    end
    rst = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; dir = 1'b0; load = 1'b0;
    lv2 = '0; lv4 = '0; lv7 = '0;
    mpos = '{0, 0, 0};
    mill = '{1'b0, 1'b0, 1'b0};
    #1;
    test_reset();
    test_count_up();
    test_dir_change();
    test_load_legal();
    test_load_illegal();
    test_illegal_fix();
    test_rst_mid();
    test_period();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
